// File: rtl/ldrw_pipe.sv
// Lattice-gas drawing stage: reduces a group of NCELL FHP cells to one ARGB pixel
// through a two-stage valid/ready pipeline, and keeps a per-frame particle total.
module ldrw_pipe #(
    parameter int          NCELL     = 4,
    parameter int          PBITS     = 7,
    parameter int          SHIFT     = 3,
    parameter logic [31:0] WALL_ARGB = 32'h00000077,
    parameter int          TOT_W     = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*NCELL-1:0] in_cells,
    input  logic [1:0]         in_mode,
    input  logic               in_sof,
    input  logic               in_eof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_argb,
    output logic [TOT_W-1:0]   frame_total,
    output logic               frame_done
);

    localparam int CW  = $clog2(NCELL*PBITS+1);
    localparam int PCW = $clog2(PBITS+1);
    // Colour arithmetic is kept at least 9 bits wide so the >255 clamp and the
    // 8-bit raw slice are always in range, even for tiny NCELL/SHIFT.
    localparam int LW  = (CW+SHIFT > 9) ? CW+SHIFT : 9;
    localparam int AW  = ((TOT_W > CW) ? TOT_W : CW) + 1;

    logic [PCW-1:0]   cell_pop [NCELL];
    logic [NCELL-1:0] wall_bits;
    logic [CW-1:0]    cnt_in;
    logic             wall_in;

    generate
        for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
            assign cell_pop[gi]  = PCW'($countones(in_cells[8*gi +: PBITS]));
            assign wall_bits[gi] = in_cells[8*gi+7];
        end
    endgenerate

    always_comb begin
        cnt_in = '0;
        for (int k = 0; k < NCELL; k++) begin
            cnt_in = cnt_in + CW'(cell_pop[k]);
        end
    end
    assign wall_in = |wall_bits;

    logic             s1_valid_q, s1_valid_d;
    logic [CW-1:0]    s1_cnt_q, s1_cnt_d;
    logic             s1_wall_q, s1_wall_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_argb_q, s2_argb_d;
    logic [TOT_W-1:0] acc_q, acc_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic             done_q, done_d;

    logic s2_adv, s1_adv, in_fire;
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    logic [LW-1:0] shl, cnt_ext;
    logic [7:0]    lvl;
    logic [31:0]   colour;

    always_comb begin
        cnt_ext = LW'(s1_cnt_q);
        shl     = cnt_ext << SHIFT;
        lvl     = (shl > LW'(255)) ? 8'hFF : shl[7:0];
        case (s1_mode_q)
            2'b00:   colour = {8'h00, lvl, lvl, lvl};
            2'b01:   colour = {8'h00, lvl, 8'h00, 8'hFF - lvl};
            2'b10:   colour = {24'h000000, cnt_ext[7:0]};
            default: colour = 32'h00000000;
        endcase
        // Raw mode reports the count even over walls.
        if (s1_wall_q && s1_mode_q != 2'b10) begin
            colour = WALL_ARGB;
        end
    end

    logic [TOT_W-1:0] acc_base, acc_next;
    logic [AW-1:0]    acc_sum;

    always_comb begin
        acc_base = in_sof ? '0 : acc_q;
        acc_sum  = AW'(acc_base) + AW'(cnt_in);
        acc_next = (acc_sum > AW'({TOT_W{1'b1}})) ? {TOT_W{1'b1}} : acc_sum[TOT_W-1:0];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cnt_d   = s1_cnt_q;
        s1_wall_d  = s1_wall_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_argb_d  = s2_argb_q;
        acc_d      = acc_q;
        total_d    = total_q;
        done_d     = 1'b0;
        if (s1_adv) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_cnt_d  = cnt_in;
                s1_wall_d = wall_in;
                s1_mode_d = in_mode;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_argb_d = colour;
            end
        end
        if (in_fire) begin
            if (in_eof) begin
                total_d = acc_next;
                acc_d   = '0;
                done_d  = 1'b1;
            end else begin
                acc_d = acc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cnt_q   <= '0;
            s1_wall_q  <= 1'b0;
            s1_mode_q  <= 2'b00;
            s2_valid_q <= 1'b0;
            s2_argb_q  <= 32'h00000000;
            acc_q      <= '0;
            total_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_wall_q  <= s1_wall_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_argb_q  <= s2_argb_d;
            acc_q      <= acc_d;
            total_q    <= total_d;
            done_q     <= done_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_argb    = s2_argb_q;
    assign frame_total = total_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_ldrw_pipe.sv
// Scoreboard bench for ldrw_pipe: pixels and frame totals predicted from driven
// beats, compared as the DUT produces them.
module tb_ldrw_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_sof, in_eof, out_valid, out_ready, frame_done;
    logic [31:0] in_cells, out_argb;
    logic [1:0]  in_mode;
    logic [23:0] frame_total;

    logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_frame_done;
    logic [63:0] d8_in_cells;
    logic [1:0]  d8_in_mode;
    logic [31:0] d8_out_argb;
    logic [23:0] d8_frame_total;

    ldrw_pipe #(.NCELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cells(in_cells),
        .in_mode(in_mode), .in_sof(in_sof), .in_eof(in_eof),
        .out_valid(out_valid), .out_ready(out_ready), .out_argb(out_argb),
        .frame_total(frame_total), .frame_done(frame_done)
    );

    ldrw_pipe #(.NCELL(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_cells(d8_in_cells),
        .in_mode(d8_in_mode), .in_sof(1'b0), .in_eof(1'b0),
        .out_valid(d8_out_valid), .out_ready(1'b1), .out_argb(d8_out_argb),
        .frame_total(d8_frame_total), .frame_done(d8_frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input logic [63:0] cells, input int ncell);
        int c = 0;
        for (int k = 0; k < ncell; k++)
            for (int b = 0; b < 7; b++)
                c += int'(cells[8*k+b]);
        return c;
    endfunction

    function automatic logic [31:0] exp_pix(input logic [63:0] cells, input logic [1:0] mode, input int ncell);
        int          c, lv;
        bit          wall;
        logic [7:0]  l8, c8;
        logic [31:0] p;
        c    = cnt_of(cells, ncell);
        wall = 0;
        for (int k = 0; k < ncell; k++) wall |= cells[8*k+7];
        lv = c * 8;
        if (lv > 255) lv = 255;
        l8 = lv[7:0];
        c8 = c[7:0];
        case (mode)
            2'b00:   p = {8'h00, l8, l8, l8};
            2'b01:   p = {8'h00, l8, 8'h00, 8'hFF - l8};
            2'b10:   p = {24'h0, c8};
            default: p = 32'h0;
        endcase
        if (wall && mode != 2'b10) p = 32'h00000077;
        return p;
    endfunction

    // Scoreboard and frame model, all sampled on the falling edge.
    logic [31:0] exp_q[$];
    int          t_q[$];
    int          cyc = 0, pipe_cnt = 0, acc_m = 0;
    bit          lat_en = 0, done_pend = 0, prev_stall = 0, bp_en = 0;
    logic [23:0] exp_total = '0;
    logic [31:0] prev_argb;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("in_ready", in_ready, !(pipe_cnt == 2 && !out_ready));
            chk("frame_done", frame_done, done_pend);
            chk("frame_total", frame_total, exp_total);
            done_pend = 0;
            if (prev_stall) chk("stall_hold", {out_valid, out_argb}, {1'b1, prev_argb});
            if (out_valid && out_ready) begin
                chk("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    int t;
                    chk("pixel", out_argb, exp_q.pop_front());
                    t = t_q.pop_front();
                    if (lat_en) chk("latency", cyc - t, 2);
                end
                pipe_cnt--;
            end
            prev_stall = out_valid && !out_ready;
            prev_argb  = out_argb;
            if (in_valid && in_ready) begin
                int s;
                exp_q.push_back(exp_pix({32'h0, in_cells}, in_mode, 4));
                t_q.push_back(cyc);
                pipe_cnt++;
                s = (in_sof ? 0 : acc_m) + cnt_of({32'h0, in_cells}, 4);
                if (s > 24'hFFFFFF) s = 24'hFFFFFF;
                if (in_eof) begin
                    exp_total = s[23:0];
                    acc_m     = 0;
                    done_pend = 1;
                end else begin
                    acc_m = s;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] cells, input logic [1:0] mode, input bit sof, input bit eof);
        bit acc = 0;
        in_cells = cells; in_mode = mode; in_sof = sof; in_eof = eof; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        in_valid = 0; in_cells = '0; in_mode = 0; in_sof = 0; in_eof = 0; out_ready = 1'b1;
        d8_in_valid = 0; d8_in_cells = '0; d8_in_mode = 0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_argb", out_argb, 0);
        chk("rst_frame_total", frame_total, 0);
        chk("rst_frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Grey full load, wall override, heat, blank wall-only.
        lat_en = 1;
        send(32'h7F7F7F7F, 2'b00, 0, 0); idle(3);
        send(32'h00803F01, 2'b00, 0, 0);
        send(32'h00803F01, 2'b01, 0, 0);
        send(32'h00803F01, 2'b11, 0, 0);
        send(32'h00803F01, 2'b10, 0, 0); idle(4);
        send(32'h00000003, 2'b01, 0, 0);
        send(32'h00000000, 2'b11, 0, 0); idle(4);

        // Eight-cell instance: clamp in grey, raw count in mode 10.
        d8_in_cells = {8{8'h7F}}; d8_in_mode = 2'b00; d8_in_valid = 1'b1;
        @(negedge clk); chk("d8_in_ready", d8_in_ready, 1);
        @(posedge clk); #1 d8_in_mode = 2'b10;
        @(posedge clk); #1 d8_in_valid = 1'b0;
        @(negedge clk); chk("d8_grey_sat", {d8_out_valid, d8_out_argb}, {1'b1, exp_pix({8{8'h7F}}, 2'b00, 8)});
        @(negedge clk); chk("d8_raw", {d8_out_valid, d8_out_argb}, {1'b1, exp_pix({8{8'h7F}}, 2'b10, 8)});
        @(posedge clk); #1;

        // Frame totals: 5+7+9, then a single-beat frame of 4.
        send(32'h0000001F, 2'b00, 1, 0);
        send(32'h0000007F, 2'b00, 0, 0);
        send(32'h0000037F, 2'b00, 0, 1); idle(3);
        chk("frame_21", frame_total, 24'd21);
        send(32'h0000000F, 2'b00, 1, 1); idle(3);
        chk("frame_4", frame_total, 24'd4);

        // Backpressure stream with random out_ready.
        lat_en = 0; bp_en = 1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] c;
            c = (32'($urandom) & 32'hFFFFFF00) | 32'(i);
            send(c, 2'(i), 0, 0);
        end
        idle(0);
        bp_en = 0; out_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of a partly received frame.
        out_ready = 1'b0;
        send(32'h0000001F, 2'b00, 1, 0);
        send(32'h0000007F, 2'b00, 0, 0); idle(2);
        chk("pre_rst_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        exp_q.delete(); t_q.delete();
        pipe_cnt = 0; acc_m = 0; exp_total = '0; done_pend = 0; prev_stall = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_frame_total", frame_total, 0);
        chk("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h0000003F, 2'b00, 0, 1); idle(3);
        chk("post_rst_frame", frame_total, 24'd6);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
